// File: rtl/ack_bus_scheduler.sv
// ack_bus_scheduler: sequential owner of the shared ack bus (mem/sha/aes/ctrl); one grant at a time, held until done or abandon.
// Latency: grant/winner_id registered one edge after req is sampled in IDLE; GAP_CYCLES dead cycles follow every release.
// Backpressure: requesters wait level-held while the bus is owned or spacing; `define ACK_TIMEOUT_EN adds forced release after TIMEOUT cycles.
module ack_bus_scheduler #(
   parameter int PRIO_MODE  = 0,
   parameter int GAP_CYCLES = 1,
   parameter int TIMEOUT    = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] grant,
   output logic [1:0] winner_id,
   output logic       ack_event,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [1:0] NO_OWNER = 2'b11;
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t     state;
   logic [1:0] last_winner;
   logic [3:0] gap_cnt;
   logic [1:0] pick_id;
   logic [1:0] cand;
   logic       release_req;
   logic       to_fire;

   // Unsupported GAP_CYCLES/TIMEOUT settings show up as this named block in the elaborated hierarchy.
   if (GAP_CYCLES < 0 || GAP_CYCLES > 15 || TIMEOUT < 2 || TIMEOUT > 1024) begin : g_cfg_out_of_range
   end

   // Round-robin scans upward from last_winner+1; the previous owner is visited last.
   always_comb begin
      pick_id = 2'd0;
      cand    = 2'd0;
      if (PRIO_MODE == 1) begin
         for (int i = 3; i >= 0; i--) begin
            if (req[i]) pick_id = 2'(i);
         end
      end else begin
         for (int i = 4; i >= 1; i--) begin
            cand = last_winner + 2'(i);
            if (req[cand]) pick_id = cand;
         end
      end
   end

   assign release_req = (state == GRANT) && (done[winner_id] || !req[winner_id]);

`ifdef ACK_TIMEOUT_EN
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
   logic [9:0] to_cnt;

   // A genuine release in the same cycle wins, so no error pulse is raised then.
   assign to_fire = (state == GRANT) && !release_req && (to_cnt == TO_LAST);
`else
   assign to_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant       <= 4'b0000;
         winner_id   <= NO_OWNER;
         ack_event   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         last_winner <= 2'd3;
         gap_cnt     <= 4'd0;
`ifdef ACK_TIMEOUT_EN
         to_cnt      <= 10'd0;
`endif
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state       <= GRANT;
                  grant       <= 4'b0001 << pick_id;
                  winner_id   <= pick_id;
                  ack_event   <= 1'b1;
                  busy        <= 1'b1;
                  last_winner <= pick_id;
`ifdef ACK_TIMEOUT_EN
                  to_cnt      <= 10'd0;
`endif
               end
            end
            GRANT: begin
               if (release_req || to_fire) begin
                  grant       <= 4'b0000;
                  winner_id   <= NO_OWNER;
                  ack_event   <= 1'b0;
                  timeout_err <= to_fire;
                  gap_cnt     <= 4'd0;
                  if (GAP_CYCLES == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= GAP;
                  end
               end
`ifdef ACK_TIMEOUT_EN
               to_cnt <= to_cnt + 10'd1;
`endif
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            default: begin
               state     <= IDLE;
               grant     <= 4'b0000;
               winner_id <= NO_OWNER;
               ack_event <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ack_bus_scheduler.sv
// Bench for ack_bus_scheduler: directed scenarios plus randomized traffic against a transaction-level owner/gap model.
// Two instances: round-robin with one gap cycle, fixed priority with two gap cycles.
module tb_ack_bus_scheduler;

   localparam int GAP_A = 1;
   localparam int GAP_B = 2;
   localparam int TO    = 8;

   typedef struct {
      int owner;     // -1 when nobody holds the bus
      int gap_left;  // dead cycles still owed after a release
      int last;
      int held;      // cycles the current owner has held the bus
      bit to_pulse;
   } model_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req_a, done_a, req_b, done_b;
   logic [3:0] grant_a, grant_b;
   logic [1:0] winner_a, winner_b;
   logic       ack_a, ack_b, busy_a, busy_b, terr_a, terr_b;
   logic [8:0] obs_a, obs_b;

   model_t ma, mb;
   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ack_bus_scheduler #(.PRIO_MODE(0), .GAP_CYCLES(GAP_A), .TIMEOUT(TO)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a), .grant(grant_a),
      .winner_id(winner_a), .ack_event(ack_a), .busy(busy_a), .timeout_err(terr_a));

   ack_bus_scheduler #(.PRIO_MODE(1), .GAP_CYCLES(GAP_B), .TIMEOUT(TO)) u_fp (
      .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b), .grant(grant_b),
      .winner_id(winner_b), .ack_event(ack_b), .busy(busy_b), .timeout_err(terr_b));

   assign obs_a = {grant_a, winner_a, ack_a, busy_a, terr_a};
   assign obs_b = {grant_b, winner_b, ack_b, busy_b, terr_b};

   function automatic int model_pick(input int mode, input int last, input logic [3:0] r);
      model_pick = -1;
      if (mode == 1) begin
         for (int i = 3; i >= 0; i--) if (r[i]) model_pick = i;
      end else begin
         for (int k = 4; k >= 1; k--) if (r[(last + k) % 4]) model_pick = (last + k) % 4;
      end
   endfunction

   task automatic model_reset(output model_t m);
      m.owner = -1; m.gap_left = 0; m.last = 3; m.held = 0; m.to_pulse = 1'b0;
   endtask

   task automatic model_step(inout model_t m, input int mode, input int gap,
                             input logic [3:0] r, input logic [3:0] d);
      bit rel, timed;
      m.to_pulse = 1'b0;
      if (m.owner >= 0) begin
         rel   = d[m.owner] || !r[m.owner];
         timed = 1'b0;
`ifdef ACK_TIMEOUT_EN
         timed = !rel && (m.held == TO);
`endif
         if (rel || timed) begin
            m.owner = -1; m.gap_left = gap; m.to_pulse = timed;
         end else begin
            m.held++;
         end
      end else if (m.gap_left > 0) begin
         m.gap_left--;
      end else if (r != 4'b0000) begin
         m.owner = model_pick(mode, m.last, r);
         m.last  = m.owner;
         m.held  = 1;
      end
   endtask

   function automatic logic [8:0] exp_out(input model_t m);
      logic [3:0] g;
      logic [1:0] w;
      g = 4'b0000; w = 2'b11;
      if (m.owner >= 0) begin
         g = 4'(1 << m.owner);
         w = 2'(m.owner);
      end
      exp_out = {g, w, (m.owner >= 0), (m.owner >= 0 || m.gap_left > 0), m.to_pulse};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(ma, 0, GAP_A, req_a, done_a);
      model_step(mb, 1, GAP_B, req_b, done_b);
      #1;
      done_a = 4'b0000;
      done_b = 4'b0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_a = 4'b0000; done_a = 4'b0000; req_b = 4'b0000; done_b = 4'b0000;
      model_reset(ma); model_reset(mb);
      #12;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if (obs_a !== 9'b0000_11_0_0_0) begin
         tests_failed++; $display("FAIL reset_rr: got %b expected %b", obs_a, 9'b0000_11_0_0_0);
      end
      tests_run++;
      if (obs_b !== 9'b0000_11_0_0_0) begin
         tests_failed++; $display("FAIL reset_fp: got %b expected %b", obs_b, 9'b0000_11_0_0_0);
      end
      req_a = 4'b0100;
      tick();
      tests_run++;
      if (grant_a !== 4'b0100) begin
         tests_failed++; $display("FAIL pre_reset_grant: got %b expected 0100", grant_a);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({grant_a, winner_a, busy_a} !== 7'b0000_11_0) begin
         tests_failed++; $display("FAIL async_reset: got %b expected 0000110", {grant_a, winner_a, busy_a});
      end
      req_a = 4'b0000;
      model_reset(ma); model_reset(mb);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (obs_a !== exp_out(ma)) begin
         tests_failed++; $display("FAIL post_reset_idle: got %b expected %b", obs_a, exp_out(ma));
      end
   endtask

   task automatic test_rr_handoff();
      do_reset();
      req_a = 4'b0110;
      tick();
      tests_run++;
      if ({grant_a, winner_a} !== 6'b0010_01) begin
         tests_failed++; $display("FAIL rr_first_grant: got %b expected 001001", {grant_a, winner_a});
      end
      done_a = 4'b0010;
      tick();
      tests_run++;
      if ({grant_a, busy_a} !== 5'b0000_1) begin
         tests_failed++; $display("FAIL rr_gap: got %b expected 00001", {grant_a, busy_a});
      end
      tick();
      tests_run++;
      if ({grant_a, busy_a} !== 5'b0000_0) begin
         tests_failed++; $display("FAIL rr_idle: got %b expected 00000", {grant_a, busy_a});
      end
      tick();
      tests_run++;
      if ({grant_a, winner_a, ack_a} !== 7'b0100_10_1) begin
         tests_failed++; $display("FAIL rr_second_grant: got %b expected 0100101", {grant_a, winner_a, ack_a});
      end
   endtask

   task automatic test_rr_fairness();
      do_reset();
      req_a = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         int w = 0;
         while (!ack_a && w < 10) begin
            tick(); w++;
         end
         tests_run++;
         if (!ack_a || winner_a !== 2'(n % 4) || obs_a !== exp_out(ma)) begin
            tests_failed++;
            $display("FAIL rr_fair_%0d: got winner %b ack %b expected winner %b ack 1", n, winner_a, ack_a, 2'(n % 4));
         end
         tick();
         done_a = 4'(1 << (n % 4));
         tick();
      end
   endtask

   task automatic test_fixed_prio();
      do_reset();
      req_b = 4'b1111;
      for (int n = 0; n < 4; n++) begin
         int w = 0;
         while (!ack_b && w < 10) begin
            tick(); w++;
         end
         tests_run++;
         if (!ack_b || {grant_b, winner_b} !== 6'b0001_00) begin
            tests_failed++;
            $display("FAIL fp_grant_%0d: got %b ack %b expected 000100 ack 1", n, {grant_b, winner_b}, ack_b);
         end
         tick();
         done_b = 4'b0001;
         tick();
      end
   endtask

   task automatic test_non_winner();
      do_reset();
      req_a = 4'b0100;
      tick();
      req_a  = 4'b1101;
      done_a = 4'b1001;
      tick();
      tests_run++;
      if (grant_a !== 4'b0100) begin
         tests_failed++; $display("FAIL ignore_other_done: got %b expected 0100", grant_a);
      end
      req_a = 4'b1001;
      tick();
      tests_run++;
      if ({grant_a, winner_a, busy_a} !== 7'b0000_11_1) begin
         tests_failed++; $display("FAIL abandon_release: got %b expected 0000111", {grant_a, winner_a, busy_a});
      end
      tick();
      tick();
      tests_run++;
      if ({grant_a, winner_a} !== 6'b1000_11) begin
         tests_failed++; $display("FAIL next_after_abandon: got %b expected 100011", {grant_a, winner_a});
      end
   endtask

   task automatic test_timeout();
      do_reset();
      req_a = 4'b0001;
      tick();
`ifdef ACK_TIMEOUT_EN
      for (int i = 1; i < TO; i++) begin
         tests_run++;
         if ({grant_a, terr_a} !== 5'b0001_0) begin
            tests_failed++; $display("FAIL to_hold_%0d: got %b expected 00010", i, {grant_a, terr_a});
         end
         tick();
      end
      tests_run++;
      if ({grant_a, terr_a} !== 5'b0001_0) begin
         tests_failed++; $display("FAIL to_hold_last: got %b expected 00010", {grant_a, terr_a});
      end
      tick();
      tests_run++;
      if ({grant_a, terr_a} !== 5'b0000_1) begin
         tests_failed++; $display("FAIL to_release: got %b expected 00001", {grant_a, terr_a});
      end
      tick();
      tests_run++;
      if (terr_a !== 1'b0) begin
         tests_failed++; $display("FAIL to_pulse_width: got %b expected 0", terr_a);
      end
`else
      for (int i = 0; i < 100; i++) begin
         tests_run++;
         if ({grant_a, terr_a} !== 5'b0001_0) begin
            tests_failed++; $display("FAIL hold_forever_%0d: got %b expected 00010", i, {grant_a, terr_a});
         end
         tick();
      end
`endif
      tests_run++;
      if (obs_a !== exp_out(ma)) begin
         tests_failed++; $display("FAIL to_model: got %b expected %b", obs_a, exp_out(ma));
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(5) == 0) req_a[i] = ~req_a[i];
            if ($urandom_range(5) == 0) req_b[i] = ~req_b[i];
         end
         if ($urandom_range(3) == 0) done_a = 4'($urandom_range(15));
         if ($urandom_range(3) == 0) done_b = 4'($urandom_range(15));
         if (c == 300) begin
            #2;
            rst_n = 1'b0;
            model_reset(ma); model_reset(mb);
            #1;
            @(negedge clk);
            rst_n = 1'b1;
         end
         tick();
         tests_run++;
         if (obs_a !== exp_out(ma)) begin
            tests_failed++; $display("FAIL rand_rr_c%0d: got %b expected %b", c, obs_a, exp_out(ma));
         end
         tests_run++;
         if (obs_b !== exp_out(mb)) begin
            tests_failed++; $display("FAIL rand_fp_c%0d: got %b expected %b", c, obs_b, exp_out(mb));
         end
      end
   endtask

   initial begin
      req_a = 4'b0000; done_a = 4'b0000; req_b = 4'b0000; done_b = 4'b0000;
      #2;
      test_reset();
      test_rr_handoff();
      test_rr_fairness();
      test_fixed_prio();
      test_non_winner();
      test_timeout();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
